// File: rtl/mem_bus_arb_pkg.sv
// Shared types, constants and the region classifier for the memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef logic [1:0] region_t;

  localparam region_t REGION0 = 2'd0;
  localparam region_t REGION1 = 2'd1;
  localparam region_t REGION2 = 2'd2;

  localparam int unsigned R1_BASE_DEF = 256;
  localparam int unsigned R2_BASE_DEF = 512;

  // Operands are widened to 64 bits by the caller so one function serves any
  // address width up to 64; the compare is plain unsigned with no wrap.
  function automatic region_t addr_region(input logic [63:0] addr,
                                          input logic [63:0] r1,
                                          input logic [63:0] r2);
    if (addr < r1) begin
      return REGION0;
    end
    if (addr < r2) begin
      return REGION1;
    end
    return REGION2;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the port that did not win last time.
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_winner
);

  // Winner select; o_winner is only meaningful while o_valid is high.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = 1'b0;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory data bus.
// Every transaction takes four cycles (arbitration, address, data, response)
// and every output comes straight from a register.
//
// state | meaning
// IDLE  | sample requests, latch the winner onto the bus registers
// ADDR  | bus_wr asserted (writes only), address/data valid on the bus
// DATA  | memory returns read data; captured into rdata at end of cycle
// RESP  | ack pulse to the granted port, rdata valid
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned R1_BASE = R1_BASE_DEF,
  parameter int unsigned R2_BASE = R2_BASE_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_wr0,
  input  logic          i_wr1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic [DW-1:0] o_rdata,
  output logic          o_bus_wr,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  output logic [1:0]    o_region
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_last;
  logic          r_grant;
  logic          r_bus_wr;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  region_t       r_region;
  logic [DW-1:0] r_rdata;
  logic          r_ack0;
  logic          r_ack1;

  logic          w_last_nxt;
  logic          w_grant_nxt;
  logic          w_bus_wr_nxt;
  logic [AW-1:0] w_bus_addr_nxt;
  logic [DW-1:0] w_bus_wdata_nxt;
  region_t       w_region_nxt;
  logic [DW-1:0] w_rdata_nxt;
  logic          w_ack0_nxt;
  logic          w_ack1_nxt;

  logic          w_pick_valid;
  logic          w_pick_winner;
  logic          w_win_wr;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  region_t       w_win_region;

  rr_pick2 u_pick (
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .i_last   (r_last),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_winner)
  );

  // Route the winning port's transaction and classify its address.
  always_comb begin
    w_win_wr     = w_pick_winner ? i_wr1    : i_wr0;
    w_win_addr   = w_pick_winner ? i_addr1  : i_addr0;
    w_win_wdata  = w_pick_winner ? i_wdata1 : i_wdata0;
    w_win_region = addr_region(64'(w_win_addr), 64'(R1_BASE), 64'(R2_BASE));
  end

  // Next-state and next-register values; bus fields hold unless a grant occurs.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_bus_wr_nxt    = 1'b0;
    w_bus_addr_nxt  = r_bus_addr;
    w_bus_wdata_nxt = r_bus_wdata;
    w_region_nxt    = r_region;
    w_rdata_nxt     = r_rdata;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = ADDR;
          w_last_nxt      = w_pick_winner;
          w_grant_nxt     = w_pick_winner;
          w_bus_wr_nxt    = w_win_wr;
          w_bus_addr_nxt  = w_win_addr;
          w_bus_wdata_nxt = w_win_wdata;
          w_region_nxt    = w_win_region;
        end
      end
      ADDR: begin
        w_state_nxt = DATA;
      end
      DATA: begin
        // Captured for writes too; the requester simply ignores it.
        w_state_nxt = RESP;
        w_rdata_nxt = i_bus_rdata;
        w_ack0_nxt  = ~r_grant;
        w_ack1_nxt  = r_grant;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_region    <= REGION0;
      r_rdata     <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
    end else begin
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_bus_wr    <= w_bus_wr_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_region    <= w_region_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata     = r_rdata;
  assign o_bus_wr    = r_bus_wr;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_region    = r_region;

endmodule
